sm_mcu_cpu_oci_dct_ctrl: RTL and testbench



---
 rtl/sm_mcu_cpu_oci_dct_pkg.sv | 15 +
 rtl/sm_mcu_cpu_oci_dct_outreg.sv | 35 +++
 rtl/sm_mcu_cpu_oci_dct_ctrl.sv | 95 +++++++++
 tb/tb_sm_mcu_cpu_oci_dct_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sm_mcu_cpu_oci_dct_pkg.sv
// Shared constants and state encoding for the OCI debug capture trace controller.
package sm_mcu_cpu_oci_dct_pkg;

   localparam int FRAG_W = 2;
   localparam int SLOTS  = 15;
   localparam int BUF_W  = FRAG_W * SLOTS;
   localparam int CNT_W  = 4;

   typedef enum logic [1:0] {
      ST_FILL  = 2'd0,
      ST_FLUSH = 2'd1,
      ST_ENDED = 2'd2
   } dct_state_t;

endpackage

// File: rtl/sm_mcu_cpu_oci_dct_outreg.sv
// Single-entry valid/ready holding register between the capture buffer and trace memory.
module sm_mcu_cpu_oci_dct_outreg #(
   parameter int BUF_W = sm_mcu_cpu_oci_dct_pkg::BUF_W,
   parameter int CNT_W = sm_mcu_cpu_oci_dct_pkg::CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [BUF_W-1:0] load_data,
   input  logic [CNT_W-1:0] load_count,
   input  logic             word_ready,
   output logic             word_valid,
   output logic [BUF_W-1:0] word_data,
   output logic [CNT_W-1:0] word_count,
   output logic             free
);

   // The slot can take a new word in the same cycle the old one drains.
   assign free = !word_valid || word_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         word_valid <= 1'b0;
         word_data  <= '0;
         word_count <= '0;
      end else if (load) begin
         word_valid <= 1'b1;
         word_data  <= load_data;
         word_count <= load_count;
      end else if (word_ready) begin
         word_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/sm_mcu_cpu_oci_dct_ctrl.sv
// Packs trace fragments LSB-first into a capture buffer, hands full words to trace memory,
// and flushes any partial word when the test ends.
module sm_mcu_cpu_oci_dct_ctrl #(
   parameter int  FRAG_W = sm_mcu_cpu_oci_dct_pkg::FRAG_W,
   parameter int  SLOTS  = sm_mcu_cpu_oci_dct_pkg::SLOTS,
   parameter int  CNT_W  = sm_mcu_cpu_oci_dct_pkg::CNT_W,
   localparam int BUF_W  = FRAG_W * SLOTS
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              frag_valid,
   input  logic [FRAG_W-1:0] frag_data,
   output logic              frag_ready,
   input  logic              test_ending,
   output logic              word_valid,
   output logic [BUF_W-1:0]  word_data,
   output logic [CNT_W-1:0]  word_count,
   input  logic              word_ready,
   output logic [BUF_W-1:0]  dct_buffer,
   output logic [CNT_W-1:0]  dct_count,
   output logic              test_has_ended
);

   import sm_mcu_cpu_oci_dct_pkg::*;

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SLOTS);

   dct_state_t        state;
   dct_state_t        state_next;
   logic [BUF_W-1:0]  buf_next;
   logic [CNT_W-1:0]  cnt_next;
   logic              free;
   logic              load;
   logic              accept;

   assign frag_ready     = (state == ST_FILL) && !test_ending && ((dct_count < FULL_CNT) || free);
   assign accept         = frag_valid && frag_ready;
   assign load           = free && (state != ST_ENDED) &&
                           ((dct_count == FULL_CNT) || ((state == ST_FLUSH) && (dct_count != '0)));
   assign test_has_ended = (state == ST_ENDED);

   always_comb begin
      state_next = state;
      case (state)
         ST_FILL:  if (test_ending) state_next = ST_FLUSH;
         ST_FLUSH: if ((dct_count == '0) && !word_valid) state_next = ST_ENDED;
         default:  state_next = state;
      endcase
   end

   // A fragment arriving with a transfer lands in slot 0 of the freshly cleared buffer.
   always_comb begin
      buf_next = dct_buffer;
      cnt_next = dct_count;
      if (load) begin
         buf_next = '0;
         cnt_next = '0;
      end
      if (accept) begin
         for (int k = 0; k < SLOTS; k++) begin
            if (cnt_next == CNT_W'(k)) buf_next[FRAG_W*k +: FRAG_W] = frag_data;
         end
         cnt_next = cnt_next + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_FILL;
         dct_buffer <= '0;
         dct_count  <= '0;
      end else begin
         state      <= state_next;
         dct_buffer <= buf_next;
         dct_count  <= cnt_next;
      end
   end

   sm_mcu_cpu_oci_dct_outreg #(
      .BUF_W (BUF_W),
      .CNT_W (CNT_W)
   ) u_outreg (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .load_data  (dct_buffer),
      .load_count (dct_count),
      .word_ready (word_ready),
      .word_valid (word_valid),
      .word_data  (word_data),
      .word_count (word_count),
      .free       (free)
   );

endmodule

// File: tb/tb_sm_mcu_cpu_oci_dct_ctrl.sv
// Bench for the DCT controller: directed vector table, corner sequences, and a random run
// checked against a queue-based model plus an end-to-end fragment scoreboard.
module tb_sm_mcu_cpu_oci_dct_ctrl;

   logic        clk = 1'b0;
   logic        reset, frag_valid, test_ending, word_ready;
   logic [1:0]  frag_data;
   logic        frag_ready, word_valid, test_has_ended;
   logic [29:0] word_data, dct_buffer;
   logic [3:0]  word_count, dct_count;

   int vectors = 0;
   int miscompares = 0;
   int words_seen = 0;

   // Model state: buffered fragments, pending output word, end-of-test phase.
   logic [1:0]  mq[$];
   logic [1:0]  sent_q[$];
   bit          m_sv, m_flush, m_end, model_on = 0;
   logic [29:0] m_sd;
   logic [3:0]  m_sc;
   bit          ready_m, acc_dut;

   sm_mcu_cpu_oci_dct_ctrl dut (
      .clk            (clk),
      .reset          (reset),
      .frag_valid     (frag_valid),
      .frag_data      (frag_data),
      .frag_ready     (frag_ready),
      .test_ending    (test_ending),
      .word_valid     (word_valid),
      .word_data      (word_data),
      .word_count     (word_count),
      .word_ready     (word_ready),
      .dct_buffer     (dct_buffer),
      .dct_count      (dct_count),
      .test_has_ended (test_has_ended)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [29:0] pack(input logic [1:0] q[$], input int n);
      logic [29:0] w = '0;
      for (int i = 0; i < n; i++) w |= 30'(q[i]) << (2 * i);
      return w;
   endfunction

   task automatic check_word();
      int n = int'(word_count);
      bit ok = (n >= 1) && (n <= 15) && (sent_q.size() >= n);
      logic [29:0] exp = '0;
      chk("word_count_range", 32'(ok), 32'd1);
      if (ok) begin
         for (int i = 0; i < n; i++) exp |= 30'(sent_q.pop_front()) << (2 * i);
         chk("word_payload", word_data, exp);
      end
      words_seen++;
   endtask

   task automatic apply(input logic r, input logic v, input logic [1:0] d,
                        input logic te, input logic wr);
      @(negedge clk);
      reset = r; frag_valid = v; frag_data = d; test_ending = te; word_ready = wr;
      #1;
      ready_m = !m_end && !m_flush && !te && ((mq.size() < 15) || !m_sv || wr);
      acc_dut = !r && v && frag_ready;
      if (model_on) begin
         chk("frag_ready", frag_ready, 32'(ready_m));
         chk("dct_count", dct_count, 32'(mq.size()));
         chk("dct_buffer", dct_buffer, pack(mq, mq.size()));
         chk("word_valid", word_valid, 32'(m_sv));
         chk("test_has_ended", test_has_ended, 32'(m_end));
         if (m_sv) begin
            chk("word_data", word_data, m_sd);
            chk("word_count", word_count, m_sc);
         end
         if (!r && word_valid && word_ready) check_word();
      end
   endtask

   task automatic tick();
      int sz;
      bit sv;
      @(posedge clk);
      if (reset) begin
         mq.delete(); sent_q.delete();
         m_sv = 0; m_sd = '0; m_sc = '0; m_flush = 0; m_end = 0;
         model_on = 1;
      end else begin
         sz = mq.size();
         sv = m_sv;
         if ((!sv || word_ready) && !m_end && ((sz == 15) || (m_flush && sz > 0))) begin
            m_sd = pack(mq, sz); m_sc = 4'(sz); m_sv = 1; mq.delete();
         end else if (word_ready) begin
            m_sv = 0;
         end
         if (frag_valid && ready_m) mq.push_back(frag_data);
         if (acc_dut) sent_q.push_back(frag_data);
         if (!m_flush && !m_end) begin
            if (test_ending) m_flush = 1;
         end else if (m_flush && sz == 0 && !sv) begin
            m_flush = 0; m_end = 1;
         end
      end
   endtask

   task automatic cyc(input logic r, input logic v, input logic [1:0] d,
                      input logic te, input logic wr);
      apply(r, v, d, te, wr);
      tick();
   endtask

   typedef struct {
      logic rst, v; logic [1:0] d; logic te, wr;
      int chkm;
      logic rdy, wv; logic [3:0] wc; logic [29:0] wd;
      logic [3:0] cnt; logic [29:0] bf; logic the;
   } vec_t;

   vec_t tbl[12];

   initial begin
      logic [29:0] exp_a;
      int drops, w0;
      logic r, te, v, wr;
      reset = 1'b1; frag_valid = 1'b0; frag_data = 2'd0; test_ending = 1'b0; word_ready = 1'b0;

      // Five 2'b11 fragments, then end of test: one partial word of 0x3FF, count 5.
      tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 30'h0,   0, 30'h0,   0};
      tbl[1]  = '{0, 1, 3, 0, 1, 2, 1, 0, 0, 30'h0,   0, 30'h0,   0};
      tbl[2]  = '{0, 1, 3, 0, 1, 1, 1, 0, 0, 30'h0,   1, 30'h3,   0};
      tbl[3]  = '{0, 1, 3, 0, 1, 1, 1, 0, 0, 30'h0,   2, 30'hF,   0};
      tbl[4]  = '{0, 1, 3, 0, 1, 1, 1, 0, 0, 30'h0,   3, 30'h3F,  0};
      tbl[5]  = '{0, 1, 3, 0, 1, 1, 1, 0, 0, 30'h0,   4, 30'hFF,  0};
      tbl[6]  = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 30'h0,   5, 30'h3FF, 0};
      tbl[7]  = '{0, 1, 3, 0, 1, 1, 0, 0, 0, 30'h0,   5, 30'h3FF, 0};
      tbl[8]  = '{0, 1, 3, 0, 1, 1, 0, 1, 5, 30'h3FF, 0, 30'h0,   0};
      tbl[9]  = '{0, 1, 3, 0, 1, 1, 0, 0, 0, 30'h0,   0, 30'h0,   0};
      tbl[10] = '{0, 1, 3, 1, 1, 1, 0, 0, 0, 30'h0,   0, 30'h0,   1};
      tbl[11] = '{0, 1, 3, 0, 1, 1, 0, 0, 0, 30'h0,   0, 30'h0,   1};

      for (int i = 0; i < 12; i++) begin
         apply(tbl[i].rst, tbl[i].v, tbl[i].d, tbl[i].te, tbl[i].wr);
         if (tbl[i].chkm != 0) begin
            chk($sformatf("tbl%0d_ready", i), frag_ready, tbl[i].rdy);
            chk($sformatf("tbl%0d_wvalid", i), word_valid, tbl[i].wv);
            chk($sformatf("tbl%0d_count", i), dct_count, tbl[i].cnt);
            chk($sformatf("tbl%0d_buffer", i), dct_buffer, tbl[i].bf);
            chk($sformatf("tbl%0d_ended", i), test_has_ended, tbl[i].the);
            if (tbl[i].chkm == 2 || tbl[i].wv) begin
               chk($sformatf("tbl%0d_wcount", i), word_count, tbl[i].wc);
               chk($sformatf("tbl%0d_wdata", i), word_data, tbl[i].wd);
            end
         end
         tick();
      end

      // Fifteen fragments 0,1,2,3,...: word appears on cycle 17.
      cyc(1, 0, 0, 0, 0);
      exp_a = '0;
      for (int k = 0; k < 15; k++) begin
         cyc(0, 1, 2'(k % 4), 0, 1);
         exp_a |= 30'(k % 4) << (2 * k);
      end
      apply(0, 0, 0, 0, 1);
      chk("A_wvalid_c16", word_valid, 0);
      chk("A_count_c16", dct_count, 15);
      tick();
      apply(0, 0, 0, 0, 1);
      chk("A_wvalid_c17", word_valid, 1);
      chk("A_wcount_c17", word_count, 15);
      chk("A_wdata_c17", word_data, exp_a);
      chk("A_count_c17", dct_count, 0);
      tick();

      // Thirty back-to-back fragments with the memory always ready.
      cyc(1, 0, 0, 0, 0);
      drops = 0;
      w0 = words_seen;
      for (int k = 0; k < 30; k++) begin
         apply(0, 1, 2'($urandom), 0, 1);
         if (!frag_ready) drops++;
         tick();
      end
      for (int k = 0; k < 4; k++) cyc(0, 0, 0, 0, 1);
      chk("B_ready_drops", drops, 0);
      chk("B_words", words_seen - w0, 2);

      // Memory stalled: buffer fills behind a pending word, then drains without loss.
      cyc(1, 0, 0, 0, 0);
      for (int k = 0; k < 40; k++) cyc(0, 1, 2'($urandom), 0, 0);
      apply(0, 1, 2'($urandom), 0, 0);
      chk("C_count_full", dct_count, 15);
      chk("C_ready_bp", frag_ready, 0);
      chk("C_wvalid_held", word_valid, 1);
      tick();
      w0 = words_seen;
      for (int k = 0; k < 40; k++) cyc(0, 1, 2'($urandom), 0, 1);
      for (int k = 0; k < 5; k++) cyc(0, 0, 0, 0, 1);
      chk("C_words_after_release", 32'(words_seen - w0 >= 3), 1);

      // End of test with nothing buffered.
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 1);
      apply(0, 0, 0, 0, 1);
      chk("D_ended_n1", test_has_ended, 0);
      tick();
      apply(0, 1, 0, 0, 1);
      chk("D_ended_n2", test_has_ended, 1);
      chk("D_no_word", word_valid, 0);
      chk("D_ready", frag_ready, 0);
      tick();
      for (int k = 0; k < 3; k++) cyc(0, 1, 0, 0, 1);
      apply(0, 0, 0, 0, 1);
      chk("D_ended_sticky", test_has_ended, 1);
      tick();

      // Reset while a word is pending and seven fragments are buffered.
      cyc(1, 0, 0, 0, 0);
      for (int k = 0; k < 22; k++) cyc(0, 1, 2'($urandom), 0, 0);
      apply(0, 0, 0, 0, 0);
      chk("E_count7", dct_count, 7);
      chk("E_pending", word_valid, 1);
      tick();
      cyc(1, 0, 0, 0, 0);
      apply(0, 0, 0, 0, 0);
      chk("E_rst_wvalid", word_valid, 0);
      chk("E_rst_wdata", word_data, 0);
      chk("E_rst_wcount", word_count, 0);
      chk("E_rst_count", dct_count, 0);
      chk("E_rst_buffer", dct_buffer, 0);
      chk("E_rst_ended", test_has_ended, 0);
      chk("E_rst_ready", frag_ready, 1);
      tick();

      // Random traffic, occasional end of test and reset.
      te = 0;
      for (int k = 0; k < 4000; k++) begin
         r  = ($urandom_range(0, 399) == 0) || (m_end && $urandom_range(0, 7) == 0);
         if ($urandom_range(0, 199) == 0) te = 1;
         if (r) te = 0;
         v  = ($urandom_range(0, 3) != 0);
         wr = ($urandom_range(0, 3) != 0);
         cyc(r, v, 2'($urandom), te, wr);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
